// File: rtl/grf_wport_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter and its MDU result FIFO.
package grf_wport_arbiter_pkg;

    localparam logic [4:0] GRF_ZERO             = 5'd0;
    localparam int         DEFAULT_DEPTH        = 2;
    localparam int         DEFAULT_STARVE_LIMIT = 4;
    localparam int         ENTRY_W              = 69;

    // One queued MDU result: destination register, write data and the PC of the producer
    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wbEntry_t;

    // Which source owns the GRF write port in the current cycle
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_W,
        GRANT_FIFO
    } grantSel_t;

endpackage

// File: rtl/grf_wport_arbiter_fifo.sv
// Small circular FIFO holding MDU results until the GRF write port is free.
module grf_wb_fifo
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               w_doPush;
    logic               w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];

    // Storage needs no reset: the count alone decides which slots are meaningful
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; the count separates full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port between the W stage and queued MDU results, tracks
// per-register pending MDU writes for decode stalls, and holds W when the queue starves.
module grf_wport_arbiter
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    output logic        w_hold,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_a3,
    input  logic        md_valid,
    input  logic [4:0]  md_a3,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    output logic        md_ready,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rt_a,
    output logic        stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int PEND_W   = $clog2(DEPTH + 1);

    logic               w_fifoPush;
    logic               w_fifoPop;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [ENTRY_W-1:0] w_headRaw;
    wbEntry_t           w_head;
    wbEntry_t           w_pushEntry;
    grantSel_t          w_grant;
    logic               w_holdReq;
    logic [31:0]        w_pendInc;
    logic [31:0]        w_pendDec;

    logic [STARVE_W-1:0] r_starve;
    logic [PEND_W-1:0]   r_pend [32];

    assign w_pushEntry = {md_a3, md_wd, md_pc};
    assign w_head      = w_headRaw;

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifoPush),
        .i_entry (w_pushEntry),
        .i_pop   (w_fifoPop),
        .o_head  (w_headRaw),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // The starve counter can only reach the limit while the FIFO still holds its entry
    assign w_holdReq = !reset && (r_starve == STARVE_W'(STARVE_LIMIT));
    assign w_hold    = w_holdReq;

    // md_ready looks only at the registered fill level, so a same-cycle pop never frees a slot early
    assign md_ready   = !reset && !w_fifoFull;
    assign w_fifoPush = md_valid && md_ready;
    assign w_fifoPop  = (w_grant == GRANT_FIFO);

    // W wins unless it targets $0 or is being held; otherwise a non-empty FIFO drains
    always_comb begin
        w_grant = GRANT_NONE;
        if (!reset) begin
            if (w_we && (w_a3 != GRF_ZERO) && !w_holdReq) begin
                w_grant = GRANT_W;
            end else if (!w_fifoEmpty) begin
                w_grant = GRANT_FIFO;
            end
        end
    end

    // Drive the GRF port from the winner; a popped $0 entry consumes the slot without writing
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        case (w_grant)
            GRANT_W: begin
                grf_we = 1'b1;
                grf_a3 = w_a3;
                grf_wd = w_wd;
                grf_pc = w_pc;
            end
            GRANT_FIFO: begin
                grf_we = (w_head.a3 != GRF_ZERO);
                grf_a3 = w_head.a3;
                grf_wd = w_head.wd;
                grf_pc = w_head.pc;
            end
            default: begin
                grf_we = 1'b0;
            end
        endcase
    end

    // Count consecutive cycles the queued head loses to W; any pop or an empty queue restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_fifoPop || w_fifoEmpty) begin
            r_starve <= '0;
        end else if (w_grant == GRANT_W) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // One-hot increment/decrement requests per register; $0 is never tracked
    always_comb begin
        w_pendInc = '0;
        w_pendDec = '0;
        if (md_issue && (md_issue_a3 != GRF_ZERO)) begin
            w_pendInc[md_issue_a3] = 1'b1;
        end
        if (w_fifoPop && (w_head.a3 != GRF_ZERO)) begin
            w_pendDec[w_head.a3] = 1'b1;
        end
    end

    // Pending counters saturate at DEPTH and floor at zero; an issue and a drain to one register cancel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_pendInc[r] && !w_pendDec[r]) begin
                    if (r_pend[r] != PEND_W'(DEPTH)) begin
                        r_pend[r] <= r_pend[r] + 1'b1;
                    end
                end else if (w_pendDec[r] && !w_pendInc[r]) begin
                    if (r_pend[r] != '0) begin
                        r_pend[r] <= r_pend[r] - 1'b1;
                    end
                end
            end
        end
    end

    assign stall = !reset &&
                   (((rs_a != GRF_ZERO) && (r_pend[rs_a] != '0)) ||
                    ((rt_a != GRF_ZERO) && (r_pend[rt_a] != '0)));

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Testbench for grf_wport_arbiter: directed scenarios with literal checks plus a
// queue-based reference model compared against the DUT every cycle.
module tb_grf_wport_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        w_hold;
    logic        md_issue;
    logic [4:0]  md_issue_a3;
    logic        md_valid;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    logic        md_ready;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } mdResult_t;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        ready;
        logic        stall;
        logic        popsFifo;
    } expect_t;

    mdResult_t modelQ[$];
    int        modelPend [32];
    int        modelStarve;

    grf_wport_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w_we        (w_we),
        .w_a3        (w_a3),
        .w_wd        (w_wd),
        .w_pc        (w_pc),
        .w_hold      (w_hold),
        .md_issue    (md_issue),
        .md_issue_a3 (md_issue_a3),
        .md_valid    (md_valid),
        .md_a3       (md_a3),
        .md_wd       (md_wd),
        .md_pc       (md_pc),
        .md_ready    (md_ready),
        .rs_a        (rs_a),
        .rt_a        (rt_a),
        .stall       (stall),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa3, input logic [31:0] wwd,
                                 input logic mv, input logic [4:0] ma3, input logic [31:0] mwd);
        w_we     = we;
        w_a3     = wa3;
        w_wd     = wwd;
        w_pc     = 32'h1000 + 32'(wa3);
        md_valid = mv;
        md_a3    = ma3;
        md_wd    = mwd;
        md_pc    = 32'h2000 + 32'(ma3);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // What the outputs must be, from the arbitration rules applied to the model's queue and counters
    function automatic expect_t modelExpect();
        expect_t e;
        logic    wWins;
        e = '0;
        if (reset) begin
            return e;
        end
        e.hold  = (modelStarve >= STARVE_LIMIT);
        e.ready = (modelQ.size() < DEPTH);
        e.stall = ((rs_a != 5'd0) && (modelPend[rs_a] > 0)) ||
                  ((rt_a != 5'd0) && (modelPend[rt_a] > 0));
        wWins = w_we && (w_a3 != 5'd0) && !e.hold;
        if (wWins) begin
            e.we = 1'b1;
            e.a3 = w_a3;
            e.wd = w_wd;
            e.pc = w_pc;
        end else if (modelQ.size() > 0) begin
            e.popsFifo = 1'b1;
            e.we = (modelQ[0].a3 != 5'd0);
            e.a3 = modelQ[0].a3;
            e.wd = modelQ[0].wd;
            e.pc = modelQ[0].pc;
        end
        return e;
    endfunction

    // Advance the reference model on each clock edge, or clear it when reset rises
    always @(posedge clk or posedge reset) begin : modelStep
        expect_t   e;
        mdResult_t popped;
        int        incReg;
        int        decReg;
        bit        wasNonEmpty;
        if (reset) begin
            modelQ.delete();
            for (int i = 0; i < 32; i++) modelPend[i] = 0;
            modelStarve = 0;
        end else begin
            e           = modelExpect();
            wasNonEmpty = (modelQ.size() > 0);
            incReg      = (md_issue && (md_issue_a3 != 5'd0)) ? int'(md_issue_a3) : 0;
            decReg      = 0;
            if (e.popsFifo) begin
                popped = modelQ.pop_front();
                decReg = int'(popped.a3);
            end
            if (md_valid && e.ready) begin
                modelQ.push_back({md_a3, md_wd, md_pc});
            end
            if (e.popsFifo || !wasNonEmpty) modelStarve = 0;
            else modelStarve++;
            if (!(incReg != 0 && incReg == decReg)) begin
                if (incReg != 0) begin
                    if (modelPend[incReg] >= DEPTH)
                        $display("[TB] protocol violation: issue to $%0d at pending limit", incReg);
                    else
                        modelPend[incReg]++;
                end
                if (decReg != 0 && modelPend[decReg] > 0) modelPend[decReg]--;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle; data is only meaningful when a write happens
    always @(negedge clk) begin : compareStep
        expect_t e;
        e = modelExpect();
        checkOutput("cyc grf_we", grf_we, e.we);
        checkOutput("cyc md_ready", md_ready, e.ready);
        checkOutput("cyc w_hold", w_hold, e.hold);
        checkOutput("cyc stall", stall, e.stall);
        if (e.we) begin
            checkOutput("cyc grf_a3", grf_a3, e.a3);
            checkOutput("cyc grf_wd", grf_wd, e.wd);
            checkOutput("cyc grf_pc", grf_pc, e.pc);
        end
    end

    initial begin
        #100000;
        testsFailed++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        md_issue    = 1'b0;
        md_issue_a3 = '0;
        rs_a        = '0;
        rt_a        = '0;
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset grf_we", grf_we, 1'b0);
        checkOutput("reset md_ready", md_ready, 1'b0);
        checkOutput("reset w_hold", w_hold, 1'b0);
        checkOutput("reset stall", stall, 1'b0);
        checkOutput("reset grf_a3", grf_a3, 5'd0);
        nextCycle();
        reset = 1'b0;
        #2;
        checkOutput("release md_ready", md_ready, 1'b1);
        checkOutput("release stall", stall, 1'b0);

        // Plain W write with an empty FIFO
        applyStimulus(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0);
        #2;
        checkOutput("w grf_we", grf_we, 1'b1);
        checkOutput("w grf_a3", grf_a3, 5'd5);
        checkOutput("w grf_wd", grf_wd, 32'h1234);
        checkOutput("w grf_pc", grf_pc, 32'h1005);
        checkOutput("w md_ready", md_ready, 1'b1);
        nextCycle();

        // MDU scoreboard: issue, stall, result accepted then written one edge later
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        md_issue = 1'b1;
        md_issue_a3 = 5'd8;
        nextCycle();
        md_issue = 1'b0;
        rs_a = 5'd8;
        #2;
        checkOutput("sb stall", stall, 1'b1);
        checkOutput("sb model pend8", 32'(modelPend[8]), 32'd1);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd8, 32'hCAFE);
        #2;
        checkOutput("sb md_ready", md_ready, 1'b1);
        checkOutput("sb no bypass", grf_we, 1'b0);
        nextCycle();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("sb grf_we", grf_we, 1'b1);
        checkOutput("sb grf_a3", grf_a3, 5'd8);
        checkOutput("sb grf_wd", grf_wd, 32'hCAFE);
        checkOutput("sb grf_pc", grf_pc, 32'h2008);
        checkOutput("sb stall write cycle", stall, 1'b1);
        nextCycle();
        #2;
        checkOutput("sb stall after pop", stall, 1'b0);
        checkOutput("sb idle grf_we", grf_we, 1'b0);
        rs_a = 5'd0;

        // Full FIFO while W keeps the port busy
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
        md_issue = 1'b1;
        md_issue_a3 = 5'd9;
        nextCycle();
        nextCycle();
        md_issue_a3 = 5'd10;
        nextCycle();
        md_issue = 1'b0;
        checkOutput("full model pend9", 32'(modelPend[9]), 32'd2);
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd9, 32'h1);
        nextCycle();
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd9, 32'h2);
        nextCycle();
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd10, 32'h3);
        #2;
        checkOutput("full md_ready", md_ready, 1'b0);
        checkOutput("full grf_a3 W", grf_a3, 5'd3);
        checkOutput("full w_hold", w_hold, 1'b0);
        checkOutput("full model size", 32'(modelQ.size()), 32'd2);
        nextCycle();
        #2;
        checkOutput("full held off", md_ready, 1'b0);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd10, 32'h3);
        #2;
        checkOutput("full pop grf_we", grf_we, 1'b1);
        checkOutput("full pop grf_a3", grf_a3, 5'd9);
        checkOutput("full pop grf_wd", grf_wd, 32'h1);
        checkOutput("full pop md_ready", md_ready, 1'b0);
        nextCycle();
        #2;
        checkOutput("full ready again", md_ready, 1'b1);
        checkOutput("full 2nd grf_wd", grf_wd, 32'h2);
        nextCycle();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("full 3rd grf_a3", grf_a3, 5'd10);
        checkOutput("full 3rd grf_wd", grf_wd, 32'h3);
        nextCycle();
        #2;
        checkOutput("full drained grf_we", grf_we, 1'b0);

        // Starvation guard: W to $3 every cycle while one result waits
        md_issue = 1'b1;
        md_issue_a3 = 5'd12;
        nextCycle();
        md_issue = 1'b0;
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd12, 32'h44);
        nextCycle();
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #2;
            checkOutput("starve no hold", w_hold, 1'b0);
            checkOutput("starve W wins", grf_a3, 5'd3);
            nextCycle();
        end
        #2;
        checkOutput("starve w_hold", w_hold, 1'b1);
        checkOutput("starve grf_we", grf_we, 1'b1);
        checkOutput("starve grf_a3", grf_a3, 5'd12);
        checkOutput("starve grf_wd", grf_wd, 32'h44);
        nextCycle();
        #2;
        checkOutput("starve hold released", w_hold, 1'b0);
        checkOutput("starve W commits a3", grf_a3, 5'd3);
        checkOutput("starve W commits wd", grf_wd, 32'h33);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        nextCycle();

        // Zero register handling
        md_issue = 1'b1;
        md_issue_a3 = 5'd0;
        nextCycle();
        md_issue = 1'b0;
        checkOutput("zero model pend0", 32'(modelPend[0]), 32'd0);
        #2;
        checkOutput("zero issue stall", stall, 1'b0);
        md_issue = 1'b1;
        md_issue_a3 = 5'd13;
        nextCycle();
        md_issue = 1'b0;
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd13, 32'h66);
        nextCycle();
        applyStimulus(1, 5'd0, 32'h77, 1, 5'd0, 32'h55);
        rt_a = 5'd13;
        #2;
        checkOutput("zero fifo granted we", grf_we, 1'b1);
        checkOutput("zero fifo granted a3", grf_a3, 5'd13);
        checkOutput("zero fifo granted wd", grf_wd, 32'h66);
        checkOutput("zero w_hold", w_hold, 1'b0);
        checkOutput("zero rt stall", stall, 1'b1);
        nextCycle();
        applyStimulus(1, 5'd0, 32'h77, 0, 5'd0, 32'h0);
        #2;
        checkOutput("zero head grf_we", grf_we, 1'b0);
        checkOutput("zero rt stall cleared", stall, 1'b0);
        nextCycle();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("zero drained md_ready", md_ready, 1'b1);
        checkOutput("zero drained grf_we", grf_we, 1'b0);
        rt_a = 5'd0;

        // Reset in the middle of a drain
        md_issue = 1'b1;
        md_issue_a3 = 5'd8;
        nextCycle();
        nextCycle();
        md_issue = 1'b0;
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd8, 32'h81);
        nextCycle();
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd8, 32'h82);
        nextCycle();
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
        rs_a = 5'd8;
        #2;
        checkOutput("rst pre stall", stall, 1'b1);
        checkOutput("rst pre md_ready", md_ready, 1'b0);
        checkOutput("rst pre model pend8", 32'(modelPend[8]), 32'd2);
        reset = 1'b1;
        #1;
        checkOutput("rst async grf_we", grf_we, 1'b0);
        checkOutput("rst async md_ready", md_ready, 1'b0);
        checkOutput("rst async stall", stall, 1'b0);
        checkOutput("rst async w_hold", w_hold, 1'b0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        checkOutput("rst after grf_we", grf_we, 1'b0);
        checkOutput("rst after stall", stall, 1'b0);
        checkOutput("rst after md_ready", md_ready, 1'b1);
        checkOutput("rst after model size", 32'(modelQ.size()), 32'd0);
        nextCycle();
        #2;
        checkOutput("rst no stale write", grf_we, 1'b0);
        rs_a = 5'd0;
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
